// File: rtl/cordic_range_reducer_pkg.sv
// Shared constants and state encoding for the CORDIC angle range reducer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cordic_rr_pkg;

  // Input angle width (signed Q4.28) and accumulator width (one guard bit).
  localparam int ANGLE_W = 32;
  localparam int ACC_W   = 33;

  // pi/2 in Q4.28. Two pi is defined as exactly four quadrants, so that
  // quadrant stepping from [0, TWO_PI) never counts past 3.
  localparam logic signed [ACC_W-1:0] PIO2   = 33'sd421657428;
  localparam logic signed [ACC_W-1:0] TWO_PI = 33'sd1686629712;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WRAP = 2'd1,
    ST_QUAD = 2'd2,
    ST_DONE = 2'd3
  } rr_state_t;

  // Sign-extend a Q4.28 angle into the accumulator width.
  function automatic logic signed [ACC_W-1:0] sext_angle(input logic [ANGLE_W-1:0] a);
    return $signed({a[ANGLE_W-1], a});
  endfunction

endpackage

// File: rtl/cordic_range_reducer_if.sv
// Request/result bundle between an angle producer and the range reducer.
// Latency: n/a (wires only).
// Backpressure: result is held until ack_reduce; beg_reduce only seen when idle.
interface cordic_range_reducer_if;
  import cordic_rr_pkg::*;

  logic                 beg_reduce;
  logic                 ack_reduce;
  logic [ANGLE_W-1:0]   angle_in;
  logic                 op_in;
  logic [ANGLE_W-1:0]   angle_red;
  logic [1:0]           region;
  logic                 op_out;
  logic                 ready_reduce;
  logic                 busy;

  // Producer / consumer side: issues requests, takes results.
  modport master (
    output beg_reduce, ack_reduce, angle_in, op_in,
    input  angle_red, region, op_out, ready_reduce, busy
  );

  // Range reducer side.
  modport slave (
    input  beg_reduce, ack_reduce, angle_in, op_in,
    output angle_red, region, op_out, ready_reduce, busy
  );

endinterface

// File: rtl/cordic_range_reducer.sv
// Reduces a Q4.28 angle into [0, pi/2) plus quadrant index for a CORDIC core.
// Latency: 3 + wrap_steps + quad_steps cycles (max 8); 1 cycle on the fast path.
// Backpressure: result held with ready_reduce until ack_reduce; beg ignored while busy.
// Optional feature: define CORDIC_RR_FASTPATH_EN to skip WRAP/QUAD for inputs already in [0, pi/2).
module cordic_range_reducer
  import cordic_rr_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  cordic_range_reducer_if.slave  rr
);

  rr_state_t                 state;
  logic signed [ACC_W-1:0]   acc;
  logic [1:0]                q;

  logic [ANGLE_W-1:0]        angle_red_r;
  logic [1:0]                region_r;
  logic                      op_out_r;
  logic                      ready_r;
  logic                      busy_r;

  logic signed [ACC_W-1:0]   angle_ext;
  logic signed [ACC_W-1:0]   addend;
  logic signed [ACC_W-1:0]   sum;
  logic                      acc_neg;
  logic                      acc_ge_2pi;
  logic                      acc_ge_pio2;

  assign angle_ext   = sext_angle(rr.angle_in);
  assign acc_neg     = acc[ACC_W-1];
  assign acc_ge_2pi  = (acc >= TWO_PI);
  assign acc_ge_pio2 = (acc >= PIO2);

`ifdef CORDIC_RR_FASTPATH_EN
  // Input already inside the first quadrant needs no reduction at all.
  logic fast_hit;
  assign fast_hit = !rr.angle_in[ANGLE_W-1] && (angle_ext < PIO2);
`endif

  // Single shared adder: operand chosen by state and accumulator sign.
  always_comb begin
    addend = '0;
    case (state)
      ST_WRAP: addend = acc_neg ? TWO_PI : -TWO_PI;
      ST_QUAD: addend = -PIO2;
      default: addend = '0;
    endcase
    sum = acc + addend;
  end

  // Control FSM with registered result outputs; reset wins over beg/ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      acc         <= '0;
      q           <= '0;
      angle_red_r <= '0;
      region_r    <= '0;
      op_out_r    <= 1'b0;
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rr.beg_reduce) begin
            acc      <= angle_ext;
            q        <= '0;
            op_out_r <= rr.op_in;
            busy_r   <= 1'b1;
`ifdef CORDIC_RR_FASTPATH_EN
            if (fast_hit) begin
              state       <= ST_DONE;
              angle_red_r <= rr.angle_in;
              region_r    <= '0;
              ready_r     <= 1'b1;
            end else begin
              state <= ST_WRAP;
            end
`else
            state <= ST_WRAP;
`endif
          end
        end

        // Fold into [0, TWO_PI) one full turn per cycle (at most two turns).
        ST_WRAP: begin
          if (acc_neg || acc_ge_2pi) begin
            acc <= sum;
          end else begin
            state <= ST_QUAD;
          end
        end

        // Peel off quadrants; q counts how many were removed.
        ST_QUAD: begin
          if (acc_ge_pio2) begin
            acc <= sum;
            q   <= q + 2'd1;
          end else begin
            state       <= ST_DONE;
            angle_red_r <= acc[ANGLE_W-1:0];
            region_r    <= q;
            ready_r     <= 1'b1;
          end
        end

        // Hold the result until the consumer acknowledges; beg is ignored here.
        ST_DONE: begin
          if (rr.ack_reduce) begin
            state   <= ST_IDLE;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        end

        default: begin
          state   <= ST_IDLE;
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign rr.angle_red    = angle_red_r;
  assign rr.region       = region_r;
  assign rr.op_out       = op_out_r;
  assign rr.ready_reduce = ready_r;
  assign rr.busy         = busy_r;

endmodule

// File: tb/tb_cordic_range_reducer.sv
// Self-checking bench for cordic_range_reducer: directed corner angles plus
// random angles compared against a modulo-arithmetic reference model.
module tb_cordic_range_reducer;

  localparam longint MODEL_PIO2   = 421657428;
  localparam longint MODEL_TWO_PI = 1686629712;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  cordic_range_reducer_if rr_if ();

  cordic_range_reducer dut (
    .clk   (clk),
    .reset (reset),
    .rr    (rr_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: true modulo of the angle by a full turn, then integer
  // division into quadrants. Latency from the count of turns removed.
  task automatic model(input logic [31:0] ang, output longint red, output longint quad,
                       output int lat);
    longint x;
    longint turns;
    longint m;
    x = longint'($signed(ang));
    if (x < 0) turns = (-x + MODEL_TWO_PI - 1) / MODEL_TWO_PI;
    else       turns = x / MODEL_TWO_PI;
    m    = (x < 0) ? x + turns * MODEL_TWO_PI : x - turns * MODEL_TWO_PI;
    quad = m / MODEL_PIO2;
    red  = m - quad * MODEL_PIO2;
    lat  = 3 + int'(turns) + int'(quad);
`ifdef CORDIC_RR_FASTPATH_EN
    if (x >= 0 && x < MODEL_PIO2) lat = 1;
`endif
  endtask

  // One full transaction: start, optional stray beg mid-flight, wait for
  // ready, hold ack low, then ack (optionally together with beg).
  task automatic run_op(input logic [31:0] ang, input logic op, input int hold,
                        input int beg_mid, input logic ack_with_beg);
    longint red;
    longint quad;
    int     lat_exp;
    int     lat;
    model(ang, red, quad, lat_exp);
    @(negedge clk);
    rr_if.beg_reduce = 1'b1;
    rr_if.angle_in   = ang;
    rr_if.op_in      = op;
    @(negedge clk);
    rr_if.beg_reduce = 1'b0;
    lat = 1;
    while (!rr_if.ready_reduce && lat < 20) begin
      if (lat == beg_mid) begin
        rr_if.beg_reduce = 1'b1;
        rr_if.angle_in   = ~ang;
        rr_if.op_in      = ~op;
      end
      @(negedge clk);
      rr_if.beg_reduce = 1'b0;
      lat++;
    end
    check("ready_seen", 64'(rr_if.ready_reduce), 64'd1);
    if (rr_if.ready_reduce) begin
      check("latency",   64'(lat),               64'(lat_exp));
      check("angle_red", 64'(rr_if.angle_red),   64'(red));
      check("region",    64'(rr_if.region),      64'(quad));
      check("op_out",    64'(rr_if.op_out),      64'(op));
      check("busy_done", 64'(rr_if.busy),        64'd1);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_ready", 64'(rr_if.ready_reduce), 64'd1);
        check("hold_red",   64'(rr_if.angle_red),    64'(red));
        check("hold_reg",   64'(rr_if.region),       64'(quad));
      end
    end
    rr_if.ack_reduce = 1'b1;
    rr_if.beg_reduce = ack_with_beg;
    rr_if.angle_in   = $urandom;
    @(negedge clk);
    rr_if.ack_reduce = 1'b0;
    rr_if.beg_reduce = 1'b0;
    check("ready_drop", 64'(rr_if.ready_reduce), 64'd0);
    check("idle_busy",  64'(rr_if.busy),         64'd0);
    @(negedge clk);
    check("no_restart", 64'(rr_if.busy),         64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    rr_if.beg_reduce = 1'b0;
    rr_if.ack_reduce = 1'b0;
    rr_if.angle_in   = '0;
    rr_if.op_in      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(rr_if.ready_reduce), 64'd0);
    check("rst_busy",  64'(rr_if.busy),         64'd0);
    check("rst_red",   64'(rr_if.angle_red),    64'd0);
    check("rst_reg",   64'(rr_if.region),       64'd0);
    check("rst_op",    64'(rr_if.op_out),       64'd0);
    reset = 1'b0;

    // Directed corners: zero, 2.0, -1.0 (held 5 cycles, stray beg in QUAD), 1.0.
    run_op(32'd0,          1'b1, 0, 0, 1'b0);
    run_op(32'd536870912,  1'b0, 1, 0, 1'b1);
    run_op(32'hF000_0000,  1'b1, 5, 4, 1'b0);
    run_op(32'd268435456,  1'b0, 2, 0, 1'b1);
    run_op(32'd421657427,  1'b1, 0, 0, 1'b0);
    run_op(32'd421657428,  1'b0, 0, 0, 1'b0);
    run_op(32'd1686629711, 1'b1, 0, 0, 1'b0);
    run_op(32'd1686629712, 1'b0, 0, 0, 1'b0);
    run_op(32'h7FFF_FFFF,  1'b1, 0, 0, 1'b0);
    run_op(32'h8000_0000,  1'b0, 0, 0, 1'b0);
    run_op(32'hFFFF_FFFF,  1'b1, 0, 0, 1'b0);

    // Reset while in WRAP aborts without a ready pulse.
    @(negedge clk);
    rr_if.beg_reduce = 1'b1;
    rr_if.angle_in   = 32'hF000_0000;
    rr_if.op_in      = 1'b1;
    @(negedge clk);
    rr_if.beg_reduce = 1'b0;
    check("wrap_busy", 64'(rr_if.busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_ready", 64'(rr_if.ready_reduce), 64'd0);
    check("abort_busy",  64'(rr_if.busy),         64'd0);
    check("abort_red",   64'(rr_if.angle_red),    64'd0);
    check("abort_reg",   64'(rr_if.region),       64'd0);
    check("abort_op",    64'(rr_if.op_out),       64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_quiet", 64'(rr_if.ready_reduce), 64'd0);
    end

    // Random angles across the whole input range.
    for (int n = 0; n < 60; n++) begin
      run_op($urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
             $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
